// File: rtl/vproc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// vproc_mem_arbiter
//
// Shares the single system memory port between the instruction-fetch port and
// the data (scalar + vector LSU) port. At most one request is granted per
// cycle and forwarded unmodified to the memory port. The ID of every granted
// request is kept in an in-order FIFO so that each in-order memory response
// can be routed back to the requester that issued it.
//
// The memory accepts a request every cycle (it has no grant) and returns
// exactly one response per request, in order, after a fixed latency >= 1.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_req_i/addr_i            fetch request (read only)
//   instr_gnt_o                   fetch request accepted this cycle
//   instr_rvalid_o/err_o/rdata_o  fetch response
//   data_req_i/addr_i/we_i/be_i/wdata_i  data request
//   data_gnt_o                    data request accepted this cycle
//   data_rvalid_o/err_o/rdata_o   data response (reads and writes)
//   mem_req_o/addr_o/we_o/be_o/wdata_o   memory request
//   mem_rvalid_i/err_i/rdata_i    memory response
//   outstanding_o                 number of in-flight requests
//   spurious_o                    sticky: response arrived with no request
//                                 outstanding (cleared by rst_i only)
// ---------------------------------------------------------------------------
module vproc_mem_arbiter #(
  parameter int unsigned MEM_W           = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned DATA_PRIO       = 0
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,

  input  logic                                       instr_req_i,
  input  logic [31:0]                                instr_addr_i,
  output logic                                       instr_gnt_o,
  output logic                                       instr_rvalid_o,
  output logic                                       instr_err_o,
  output logic [MEM_W-1:0]                           instr_rdata_o,

  input  logic                                       data_req_i,
  input  logic [31:0]                                data_addr_i,
  input  logic                                       data_we_i,
  input  logic [MEM_W/8-1:0]                         data_be_i,
  input  logic [MEM_W-1:0]                           data_wdata_i,
  output logic                                       data_gnt_o,
  output logic                                       data_rvalid_o,
  output logic                                       data_err_o,
  output logic [MEM_W-1:0]                           data_rdata_o,

  output logic                                       mem_req_o,
  output logic [31:0]                                mem_addr_o,
  output logic                                       mem_we_o,
  output logic [MEM_W/8-1:0]                         mem_be_o,
  output logic [MEM_W-1:0]                           mem_wdata_o,
  input  logic                                       mem_rvalid_i,
  input  logic                                       mem_err_i,
  input  logic [MEM_W-1:0]                           mem_rdata_i,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
  output logic                                       spurious_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Requester IDs stored in the FIFO and in the round-robin state.
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] id_fifo_reg;
  logic [PTR_W-1:0]           wr_ptr_reg;
  logic [PTR_W-1:0]           rd_ptr_reg;
  logic [CNT_W-1:0]           count_reg;
  logic                       rr_last_reg;
  logic                       spurious_reg;

  logic                       slot_free;
  logic                       fifo_empty;
  logic                       instr_gnt;
  logic                       data_gnt;
  logic                       push;
  logic                       pop;
  logic                       push_id;
  logic                       head_id;

  // A response popping in this cycle does not free its slot until the next
  // cycle, so the grant decision only looks at the registered count.
  assign slot_free  = (count_reg < CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_reg == '0);

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst_i && slot_free) begin
      if (instr_req_i && data_req_i) begin
        // Fixed priority for data, otherwise the port not granted last wins.
        if ((DATA_PRIO != 0) || (rr_last_reg == ID_INSTR)) begin
          data_gnt = 1'b1;
        end else begin
          instr_gnt = 1'b1;
        end
      end else begin
        instr_gnt = instr_req_i;
        data_gnt  = data_req_i;
      end
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;
  assign push        = instr_gnt | data_gnt;
  assign push_id     = data_gnt ? ID_DATA : ID_INSTR;

  // -------------------------------------------------------------------------
  // Memory request mux. With no data grant the instr port is forwarded, which
  // also defines the idle values (read, all bytes, zero write data).
  // -------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = push;
    mem_addr_o  = instr_addr_i;
    mem_we_o    = 1'b0;
    mem_be_o    = '1;
    mem_wdata_o = '0;
    if (data_gnt) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // -------------------------------------------------------------------------
  // Response routing from the FIFO head. Responses with nothing outstanding
  // are dropped here and flagged through spurious_o.
  // -------------------------------------------------------------------------
  assign pop     = mem_rvalid_i & ~fifo_empty;
  assign head_id = id_fifo_reg[rd_ptr_reg];

  assign instr_rvalid_o = ~rst_i & pop & (head_id == ID_INSTR);
  assign data_rvalid_o  = ~rst_i & pop & (head_id == ID_DATA);
  assign instr_err_o    = ~rst_i & pop & mem_err_i & (head_id == ID_INSTR);
  assign data_err_o     = ~rst_i & pop & mem_err_i & (head_id == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  // -------------------------------------------------------------------------
  // ID FIFO storage, one flop per slot.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < int'(MAX_OUTSTANDING); gi++) begin : g_id_slot
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          id_fifo_reg[gi] <= ID_INSTR;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          id_fifo_reg[gi] <= push_id;
        end
      end
    end
  endgenerate

  // Pointers wrap modulo MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rr_last_reg  <= ID_DATA;   // instr wins the first conflict
      spurious_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
        rr_last_reg <= push_id;
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (mem_rvalid_i && fifo_empty) begin
        spurious_reg <= 1'b1;
      end
    end
  end

  assign outstanding_o = count_reg;
  assign spurious_o    = spurious_reg;

endmodule

// File: tb/tb_vproc_mem_arbiter.sv
module tb_vproc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i = 1'b0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'hF;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [2:0]  outstanding_o;
  logic        spurious_o;

  // Second instance with fixed data priority; its memory side stays silent.
  logic        p_instr_req_i = 1'b0;
  logic        p_data_req_i = 1'b0;
  logic        p_instr_gnt_o, p_instr_rvalid_o, p_instr_err_o;
  logic [31:0] p_instr_rdata_o;
  logic        p_data_gnt_o, p_data_rvalid_o, p_data_err_o;
  logic [31:0] p_data_rdata_o;
  logic        p_mem_req_o, p_mem_we_o;
  logic [31:0] p_mem_addr_o, p_mem_wdata_o;
  logic [3:0]  p_mem_be_o;
  logic [2:0]  p_outstanding_o;
  logic        p_spurious_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vproc_mem_arbiter #(.MEM_W(32), .MAX_OUTSTANDING(4), .DATA_PRIO(0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i),
    .mem_rdata_i(mem_rdata_i), .outstanding_o(outstanding_o), .spurious_o(spurious_o)
  );

  vproc_mem_arbiter #(.MEM_W(32), .MAX_OUTSTANDING(4), .DATA_PRIO(1)) dut_prio (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_i(p_instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(p_instr_gnt_o),
    .instr_rvalid_o(p_instr_rvalid_o), .instr_err_o(p_instr_err_o), .instr_rdata_o(p_instr_rdata_o),
    .data_req_i(p_data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(p_data_gnt_o),
    .data_rvalid_o(p_data_rvalid_o), .data_err_o(p_data_err_o), .data_rdata_o(p_data_rdata_o),
    .mem_req_o(p_mem_req_o), .mem_addr_o(p_mem_addr_o), .mem_we_o(p_mem_we_o), .mem_be_o(p_mem_be_o),
    .mem_wdata_o(p_mem_wdata_o), .mem_rvalid_i(1'b0), .mem_err_i(1'b0),
    .mem_rdata_i(32'h0), .outstanding_o(p_outstanding_o), .spurious_o(p_spurious_o)
  );

  function automatic logic [31:0] rdata_of(input logic [31:0] addr);
    return {addr[15:0] ^ 16'hC3A5, addr[31:16] ^ 16'h0F1E};
  endfunction

  // ---------------- memory model: fixed latency, in order ----------------
  typedef struct { int due; logic [31:0] data; logic err; } mresp_t;
  mresp_t mq[$];
  int   cyc = 0;
  int   mem_lat = 1;
  logic mem_err_mode = 1'b0;

  always @(negedge clk) begin
    if (mem_req_o) mq.push_back('{cyc + mem_lat, rdata_of(mem_addr_o), mem_err_mode});
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mq[0].data;
      mem_err_i    = mq[0].err;
      void'(mq.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      mem_err_i    = 1'b0;
    end
  end

  // ---------------- scoreboard: expected responses in order ----------------
  typedef struct { logic port; logic [31:0] data; logic err; } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (instr_rvalid_o || data_rvalid_o) begin
      tests_run++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_rvalid: instr_rvalid=%0b data_rvalid=%0b required none", instr_rvalid_o, data_rvalid_o);
        tests_failed++;
      end else begin
        e = sb.pop_front();
        if ((instr_rvalid_o && data_rvalid_o) || (data_rvalid_o !== e.port) ||
            (instr_rdata_o !== e.data) || (data_rdata_o !== e.data) ||
            ((e.port ? data_err_o : instr_err_o) !== e.err) ||
            ((e.port ? instr_err_o : data_err_o) !== 1'b0)) begin
          $display("FAIL response: got irv=%0b drv=%0b ierr=%0b derr=%0b rdata=%h required port=%0b err=%0b rdata=%h",
                   instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, instr_rdata_o, e.port, e.err, e.data);
          tests_failed++;
        end else begin
          $display("[TB] resp port=%0s err=%0b rdata=%h", e.port ? "data" : "instr", e.err, e.data);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    p_instr_req_i = 1'b0;
    p_data_req_i = 1'b0;
    next_cycle();
    rst_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() > 0 || mq.size() > 0) && n < budget) begin
      next_cycle();
      n++;
    end
    next_cycle();
    if (sb.size() > 0 || mq.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", sb.size() + mq.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    instr_req_i = 1'b1;
    data_req_i = 1'b1;
    p_instr_req_i = 1'b1;
    p_data_req_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({instr_gnt_o, data_gnt_o, mem_req_o, p_instr_gnt_o, p_data_gnt_o} !== 5'b0) begin
      $display("FAIL reset_gnt: got %b required 00000", {instr_gnt_o, data_gnt_o, mem_req_o, p_instr_gnt_o, p_data_gnt_o});
      tests_failed++;
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (outstanding_o !== 3'd0 || spurious_o !== 1'b0) begin
      $display("FAIL reset_state: got outstanding=%0d spurious=%0b required 0 0", outstanding_o, spurious_o);
      tests_failed++;
    end
    $display("[TB] reset checked");
    apply_reset();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    mem_lat = 1;
    instr_req_i = 1'b1;
    instr_addr_i = 32'h100;
    @(negedge clk);
    tests_run++;
    if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 ||
        mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
      $display("FAIL fetch_req: got gnt=%0b/%0b req=%0b addr=%h we=%0b be=%h required 1/0 1 00000100 0 f",
               instr_gnt_o, data_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
      tests_failed++;
    end
    sb.push_back('{1'b0, rdata_of(32'h100), 1'b0});
    next_cycle();
    instr_req_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (instr_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0 || instr_rdata_o !== rdata_of(32'h100) || outstanding_o !== 3'd1) begin
      $display("FAIL fetch_resp: got irv=%0b drv=%0b rdata=%h out=%0d required 1 0 %h 1",
               instr_rvalid_o, data_rvalid_o, instr_rdata_o, outstanding_o, rdata_of(32'h100));
      tests_failed++;
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (outstanding_o !== 3'd0) begin
      $display("FAIL fetch_drained: got outstanding=%0d required 0", outstanding_o);
      tests_failed++;
    end
    $display("[TB] single fetch addr=00000100");
    drain(20);
  endtask

  task automatic test_round_robin();
    logic exp_d;
    apply_reset();
    mem_lat = 2;
    instr_req_i = 1'b1;
    instr_addr_i = 32'h40;
    data_req_i = 1'b1;
    data_addr_i = 32'h80;
    data_we_i = 1'b0;
    data_be_i = 4'hF;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2) == 1;
      @(negedge clk);
      tests_run++;
      if (instr_gnt_o !== !exp_d || data_gnt_o !== exp_d) begin
        $display("FAIL rr_grant%0d: got instr=%0b data=%0b required instr=%0b data=%0b", i, instr_gnt_o, data_gnt_o, !exp_d, exp_d);
        tests_failed++;
      end
      $display("[TB] rr cycle %0d grant %0s", i, exp_d ? "data" : "instr");
      sb.push_back('{exp_d, rdata_of(exp_d ? 32'h80 : 32'h40), 1'b0});
      next_cycle();
    end
    instr_req_i = 1'b0;
    data_req_i = 1'b0;
    drain(30);
  endtask

  task automatic test_data_prio();
    apply_reset();
    p_instr_req_i = 1'b1;
    p_data_req_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (p_data_gnt_o !== 1'b1 || p_instr_gnt_o !== 1'b0) begin
        $display("FAIL prio_grant%0d: got instr=%0b data=%0b required instr=0 data=1", i, p_instr_gnt_o, p_data_gnt_o);
        tests_failed++;
      end
      $display("[TB] prio cycle %0d grant data", i);
      next_cycle();
    end
    p_data_req_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (p_instr_gnt_o !== 1'b1) begin
      $display("FAIL prio_instr_after: got instr_gnt=%0b required 1", p_instr_gnt_o);
      tests_failed++;
    end
    next_cycle();
    p_instr_req_i = 1'b0;
  endtask

  task automatic test_full();
    logic       exp_gnt [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] exp_out [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd3};
    apply_reset();
    mem_lat = 6;
    data_req_i = 1'b1;
    data_we_i = 1'b0;
    data_be_i = 4'hF;
    data_addr_i = 32'h300;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tests_run++;
      if (data_gnt_o !== exp_gnt[i] || outstanding_o !== exp_out[i]) begin
        $display("FAIL full_cycle%0d: got gnt=%0b outstanding=%0d required gnt=%0b outstanding=%0d",
                 i, data_gnt_o, outstanding_o, exp_gnt[i], exp_out[i]);
        tests_failed++;
      end
      $display("[TB] full cycle %0d gnt=%0b outstanding=%0d", i, exp_gnt[i], exp_out[i]);
      if (exp_gnt[i]) sb.push_back('{1'b1, rdata_of(data_addr_i), 1'b0});
      next_cycle();
      if (exp_gnt[i]) data_addr_i = data_addr_i + 32'd4;
    end
    data_req_i = 1'b0;
    drain(40);
  endtask

  task automatic test_write();
    apply_reset();
    mem_lat = 3;
    data_req_i = 1'b1;
    data_we_i = 1'b1;
    data_be_i = 4'b0101;
    data_addr_i = 32'h2000;
    data_wdata_i = 32'hA5A5_5A5A;
    @(negedge clk);
    tests_run++;
    if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000 ||
        mem_we_o !== 1'b1 || mem_be_o !== 4'b0101 || mem_wdata_o !== 32'hA5A5_5A5A) begin
      $display("FAIL write_mirror: got gnt=%0b req=%0b addr=%h we=%0b be=%b wdata=%h required 1 1 00002000 1 0101 a5a55a5a",
               data_gnt_o, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
      tests_failed++;
    end
    $display("[TB] write addr=00002000 be=0101 wdata=a5a55a5a");
    sb.push_back('{1'b1, rdata_of(32'h2000), 1'b0});
    next_cycle();
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_be_i = 4'hF;
    drain(20);
    mem_err_mode = 1'b1;
    data_req_i = 1'b1;
    data_addr_i = 32'h2004;
    @(negedge clk);
    tests_run++;
    if (data_gnt_o !== 1'b1) begin
      $display("FAIL err_req_gnt: got %0b required 1", data_gnt_o);
      tests_failed++;
    end
    $display("[TB] read with error addr=00002004");
    sb.push_back('{1'b1, rdata_of(32'h2004), 1'b1});
    next_cycle();
    data_req_i = 1'b0;
    drain(20);
    mem_err_mode = 1'b0;
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    mem_lat = 4;
    data_req_i = 1'b1;
    data_addr_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      data_addr_i = data_addr_i + 32'd4;
    end
    data_req_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    tests_run++;
    if (outstanding_o !== 3'd3) begin
      $display("FAIL inflight_count: got %0d required 3", outstanding_o);
      tests_failed++;
    end
    next_cycle();
    rst_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (outstanding_o !== 3'd0 || spurious_o !== 1'b0) begin
      $display("FAIL inflight_reset: got outstanding=%0d spurious=%0b required 0 0", outstanding_o, spurious_o);
      tests_failed++;
    end
    drain(20);
    tests_run++;
    if (spurious_o !== 1'b1 || outstanding_o !== 3'd0) begin
      $display("FAIL spurious_set: got spurious=%0b outstanding=%0d required 1 0", spurious_o, outstanding_o);
      tests_failed++;
    end
    $display("[TB] reset with 3 in flight, late responses dropped");
    mem_lat = 1;
    instr_req_i = 1'b1;
    instr_addr_i = 32'h500;
    sb.push_back('{1'b0, rdata_of(32'h500), 1'b0});
    next_cycle();
    instr_req_i = 1'b0;
    drain(20);
    tests_run++;
    if (spurious_o !== 1'b1) begin
      $display("FAIL spurious_sticky: got %0b required 1", spurious_o);
      tests_failed++;
    end
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (spurious_o !== 1'b0) begin
      $display("FAIL spurious_clear: got %0b required 0", spurious_o);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_data_prio();
    test_full();
    test_write();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
